// File: rtl/cal_sweep_pkg.sv
// Shared types and helpers for the calibration sweep sequencer.
package cal_sweep_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_ACCUM,
    ST_EMIT,
    ST_FIN
  } state_t;

  localparam int POINT_W = 4;

  function automatic int acc_width(input int w, input int avg_log2);
    return w + avg_log2;
  endfunction

endpackage

// File: rtl/cal_sweep_accum.sv
// Four-channel signed accumulator; outputs are the floor average over 2^AVG_LOG2 samples.
module cal_sweep_accum
  import cal_sweep_pkg::*;
#(
  parameter int W        = 16,
  parameter int AVG_LOG2 = 6
) (
  input  logic         clk_256fs,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] sample [4],
  output logic [W-1:0] avg    [4]
);

  localparam int AW = acc_width(W, AVG_LOG2);

  logic signed [AW-1:0] acc [4];

  always_ff @(posedge clk_256fs or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) acc[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < 4; i++) acc[i] <= '0;
    end else if (en) begin
      for (int i = 0; i < 4; i++) acc[i] <= acc[i] + AW'($signed(sample[i]));
    end
  end

  // Arithmetic shift floors toward -inf; the sum of 2^AVG_LOG2 W-bit samples always fits.
  for (genvar g = 0; g < 4; g++) begin : g_avg
    assign avg[g] = W'(acc[g] >>> AVG_LOG2);
  end

endmodule

// File: rtl/cal_sweep_ctrl.sv
// Steps force_dac_output through a setpoint ladder, averages ADC samples per point and hands results out.
//   state  | meaning
//   IDLE   | not forcing, waiting for start
//   SETTLE | setpoint applied, discarding SETTLE strobes
//   ACCUM  | accumulating 2^AVG_LOG2 strobes
//   EMIT   | result valid, waiting for res_ready
//   FIN    | done pulse, release the DAC
module cal_sweep_ctrl
  import cal_sweep_pkg::*;
#(
  parameter int W        = 16,
  parameter int N_POINTS = 5,
  parameter int SP_START = -16000,
  parameter int SP_STEP  = 8000,
  parameter int SETTLE   = 64,
  parameter int AVG_LOG2 = 6
) (
  input  logic               clk_256fs,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic               sample_strobe,
  input  logic [W-1:0]       sample_adc0,
  input  logic [W-1:0]       sample_adc1,
  input  logic [W-1:0]       sample_adc2,
  input  logic [W-1:0]       sample_adc3,
  output logic [W-1:0]       force_dac_output,
  output logic               busy,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [POINT_W-1:0] res_point,
  output logic [W-1:0]       res_setpoint,
  output logic [W-1:0]       res_avg0,
  output logic [W-1:0]       res_avg1,
  output logic [W-1:0]       res_avg2,
  output logic [W-1:0]       res_avg3,
  output logic               done
);

  localparam int                 CNT_W      = 11;
  localparam logic [W-1:0]       SP_START_W = W'(SP_START);
  localparam logic [W-1:0]       SP_STEP_W  = W'(SP_STEP);
  localparam logic [CNT_W-1:0]   SETTLE_LD  = CNT_W'(SETTLE);
  localparam logic [CNT_W-1:0]   AVG_LD     = CNT_W'(1 << AVG_LOG2);
  localparam logic [POINT_W-1:0] LAST_PT    = POINT_W'(N_POINTS - 1);

  // A zero code would release the pmod, so a zero setpoint is forced as 1 LSB.
  function automatic logic [W-1:0] dac_code(input logic [W-1:0] sp);
    return (sp == '0) ? W'(1) : sp;
  endfunction

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [W-1:0]       setpoint;
  logic [POINT_W-1:0] point;
  logic [W-1:0]       next_sp;
  logic               acc_clr;
  logic               acc_en;
  logic [W-1:0]       samples [4];
  logic [W-1:0]       avgs    [4];

  assign next_sp = setpoint + SP_STEP_W;
  assign acc_clr = (state == ST_SETTLE) && sample_strobe && !abort && (cnt == CNT_W'(1));
  assign acc_en  = (state == ST_ACCUM) && sample_strobe && !abort;

  always_ff @(posedge clk_256fs or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_IDLE;
      cnt              <= '0;
      setpoint         <= '0;
      point            <= '0;
      force_dac_output <= '0;
      busy             <= 1'b0;
      res_valid        <= 1'b0;
      done             <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort && state != ST_IDLE) begin
        state            <= ST_IDLE;
        force_dac_output <= '0;
        res_valid        <= 1'b0;
        busy             <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start && !abort) begin
              point            <= '0;
              setpoint         <= SP_START_W;
              force_dac_output <= dac_code(SP_START_W);
              busy             <= 1'b1;
              cnt              <= SETTLE_LD;
              state            <= ST_SETTLE;
            end
          end
          ST_SETTLE: begin
            if (sample_strobe) begin
              if (cnt == CNT_W'(1)) begin
                cnt   <= AVG_LD;
                state <= ST_ACCUM;
              end else begin
                cnt <= cnt - CNT_W'(1);
              end
            end
          end
          ST_ACCUM: begin
            if (sample_strobe) begin
              if (cnt == CNT_W'(1)) begin
                res_valid <= 1'b1;
                state     <= ST_EMIT;
              end else begin
                cnt <= cnt - CNT_W'(1);
              end
            end
          end
          ST_EMIT: begin
            if (res_ready) begin
              res_valid <= 1'b0;
              if (point != LAST_PT) begin
                point            <= point + POINT_W'(1);
                setpoint         <= next_sp;
                force_dac_output <= dac_code(next_sp);
                cnt              <= SETTLE_LD;
                state            <= ST_SETTLE;
              end else begin
                done  <= 1'b1;
                state <= ST_FIN;
              end
            end
          end
          ST_FIN: begin
            force_dac_output <= '0;
            busy             <= 1'b0;
            state            <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign samples[0] = sample_adc0;
  assign samples[1] = sample_adc1;
  assign samples[2] = sample_adc2;
  assign samples[3] = sample_adc3;

  cal_sweep_accum #(
    .W        (W),
    .AVG_LOG2 (AVG_LOG2)
  ) u_accum (
    .clk_256fs (clk_256fs),
    .rst_n     (rst_n),
    .clr       (acc_clr),
    .en        (acc_en),
    .sample    (samples),
    .avg       (avgs)
  );

  assign res_point    = point;
  assign res_setpoint = setpoint;
  assign res_avg0     = avgs[0];
  assign res_avg1     = avgs[1];
  assign res_avg2     = avgs[2];
  assign res_avg3     = avgs[3];

endmodule

// File: tb/tb_cal_sweep_ctrl.sv
// Directed bench for cal_sweep_ctrl with a short 3-point ladder (-100, 0, 100), SETTLE=3, 4-sample averages.
module tb_cal_sweep_ctrl;

  logic        clk_256fs = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        sample_strobe = 1'b0;
  logic        res_ready = 1'b1;
  logic [15:0] sample_adc0 = '0;
  logic [15:0] sample_adc1 = '0;
  logic [15:0] sample_adc2 = '0;
  logic [15:0] sample_adc3 = '0;
  logic [15:0] force_dac_output;
  logic        busy;
  logic        res_valid;
  logic [3:0]  res_point;
  logic [15:0] res_setpoint;
  logic [15:0] res_avg0, res_avg1, res_avg2, res_avg3;
  logic        done;

  int checks   = 0;
  int failures = 0;
  logic stable;

  cal_sweep_ctrl #(
    .W        (16),
    .N_POINTS (3),
    .SP_START (-100),
    .SP_STEP  (100),
    .SETTLE   (3),
    .AVG_LOG2 (2)
  ) dut (
    .clk_256fs        (clk_256fs),
    .rst_n            (rst_n),
    .start            (start),
    .abort            (abort),
    .sample_strobe    (sample_strobe),
    .sample_adc0      (sample_adc0),
    .sample_adc1      (sample_adc1),
    .sample_adc2      (sample_adc2),
    .sample_adc3      (sample_adc3),
    .force_dac_output (force_dac_output),
    .busy             (busy),
    .res_valid        (res_valid),
    .res_ready        (res_ready),
    .res_point        (res_point),
    .res_setpoint     (res_setpoint),
    .res_avg0         (res_avg0),
    .res_avg1         (res_avg1),
    .res_avg2         (res_avg2),
    .res_avg3         (res_avg3),
    .done             (done)
  );

  always #5 clk_256fs = ~clk_256fs;

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_256fs);
  endtask

  task automatic strobe(input int a0, input int a1, input int a2, input int a3);
    sample_adc0   = 16'(a0);
    sample_adc1   = 16'(a1);
    sample_adc2   = 16'(a2);
    sample_adc3   = 16'(a3);
    sample_strobe = 1'b1;
    tick();
    sample_strobe = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Settle samples carry a large value so any leak into the average is visible.
  task automatic settle3();
    repeat (3) strobe(12345, 12345, 12345, 12345);
  endtask

  task automatic run_point(input int a0, input int a1, input int a2, input int a3,
                           input int pt, input int sp);
    settle3();
    repeat (4) strobe(a0, a1, a2, a3);
    check("pt_valid", res_valid, 1);
    check("pt_index", res_point, pt);
    check("pt_setpoint", $signed(res_setpoint), sp);
    check("pt_avg0", $signed(res_avg0), a0);
    check("pt_avg1", $signed(res_avg1), a1);
    check("pt_avg2", $signed(res_avg2), a2);
    check("pt_avg3", $signed(res_avg3), a3);
  endtask

  initial begin
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_force", force_dac_output, 0);
    check("rst_valid", res_valid, 0);
    check("rst_done", done, 0);
    check("rst_avg0", res_avg0, 0);
    check("rst_point", res_point, 0);
    rst_n = 1'b1;
    tick();

    // basic sweep
    do_start();
    check("start_busy", busy, 1);
    check("start_force", $signed(force_dac_output), -100);
    run_point(10, -10, 0, 32767, 0, -100);
    tick();
    check("hs_valid_fall", res_valid, 0);
    check("force_zero_sp", $signed(force_dac_output), 1);
    check("sp_zero_report", $signed(res_setpoint), 0);
    run_point(10, -10, 0, 32767, 1, 0);
    tick();
    check("force_pt2", $signed(force_dac_output), 100);
    run_point(10, -10, 0, 32767, 2, 100);
    tick();
    check("done_pulse", done, 1);
    check("fin_busy", busy, 1);
    tick();
    check("done_fall", done, 0);
    check("fin_force", force_dac_output, 0);
    check("fin_busy_low", busy, 0);

    // floor averaging
    do_start();
    settle3();
    strobe(1, 0, 0, 0);
    repeat (3) strobe(2, 0, 0, 0);
    check("avg_floor_pos", $signed(res_avg0), 1);
    tick();
    settle3();
    strobe(-1, 0, 0, 0);
    repeat (3) strobe(0, 0, 0, 0);
    check("avg_floor_neg", $signed(res_avg0), -1);
    tick();

    // backpressure on the last point
    res_ready = 1'b0;
    run_point(100, 200, -300, 7, 2, 100);
    stable = 1'b1;
    repeat (10) begin
      strobe(1, 1, 1, 1);
      repeat (4) tick();
      if (!(res_valid && res_avg0 == 16'd100 && res_avg2 == 16'hFED4 &&
            force_dac_output == 16'd100 && res_point == 4'd2)) stable = 1'b0;
    end
    check("bp_stable", stable, 1);
    res_ready = 1'b1;
    tick();
    check("bp_release_done", done, 1);
    tick();
    check("bp_idle", busy, 0);

    // abort during accumulation of point 1
    do_start();
    run_point(5, 5, 5, 5, 0, -100);
    tick();
    settle3();
    repeat (2) strobe(5, 5, 5, 5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_force", force_dac_output, 0);
    check("abort_valid", res_valid, 0);
    check("abort_done", done, 0);
    tick();
    check("abort_no_done", done, 0);
    do_start();
    check("restart_point", res_point, 0);
    check("restart_force", $signed(force_dac_output), -100);

    // start while busy must not disturb the ladder
    run_point(0, 0, 0, 0, 0, -100);
    tick();
    do_start();
    check("busy_start_point", res_point, 1);
    check("busy_start_force", $signed(force_dac_output), 1);

    // strobe coinciding with the handshake is not a settle strobe
    settle3();
    repeat (4) strobe(0, 0, 0, 0);
    check("coinc_valid", res_valid, 1);
    strobe(9, 9, 9, 9);
    check("coinc_hs", res_valid, 0);
    check("coinc_point", res_point, 2);
    repeat (2) strobe(12345, 12345, 12345, 12345);
    strobe(4000, 4000, 4000, 4000);
    repeat (3) strobe(0, 0, 0, 0);
    check("coinc_not_yet", res_valid, 0);
    strobe(0, 0, 0, 0);
    check("coinc_valid2", res_valid, 1);
    check("coinc_avg0", $signed(res_avg0), 0);
    tick();
    check("coinc_done", done, 1);
    tick();

    // start and abort together in IDLE
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("sa_busy", busy, 0);
    check("sa_force", force_dac_output, 0);
    tick();
    check("sa_busy2", busy, 0);

    // async reset while a result is pending
    res_ready = 1'b0;
    do_start();
    run_point(10, 20, 30, 40, 0, -100);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", res_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_force", force_dac_output, 0);
    check("arst_avg0", res_avg0, 0);
    check("arst_setpoint", res_setpoint, 0);
    tick();
    rst_n = 1'b1;
    tick();
    res_ready = 1'b1;
    do_start();
    run_point(7, -7, 70, -70, 0, -100);
    tick();
    run_point(1, 2, 3, 4, 1, 0);
    tick();
    run_point(-5, 6, -7, 8, 2, 100);
    tick();
    check("post_rst_done", done, 1);
    tick();
    check("post_rst_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
